rr_hold_arbiter: RTL and testbench
==================================

// Module: rr_hold_arbiter
// PURPOSE
//  Round-robin arbiter with grant hold (lock) for one shared resource among N requesters.
//  A requester keeps its grant while its req stays high; MAX_HOLD bounds ownership when others wait.
//  Registered one-hot grant plus encoded owner id; sits in front of a shared bus/port/datapath.
// PARAMETERS
//  N         4   number of requesters (>=2)
//  MAX_HOLD  8   max owned cycles before preemption if others wait; 0 = never preempt
// PORTS
//  clk         in   1           single clock, rising edge
//  rst         in   1           synchronous, active-high reset
//  req         in   N           request lines, level; bit i = requester i
//  grant       out  N           registered one-hot grant, 0 when idle
//  grant_valid out  1           |grant, registered
//  grant_id    out  $clog2(N)   index of current owner; 0 when idle
// BEHAVIOUR
//  Reset: grant=0, grant_valid=0, grant_id=0, state=IDLE, ptr=0, hold_cnt=0.
//   rst wins over all; mid-ownership reset drops grant at that edge, next arbitration starts at req[0].
//  Pick function: masked = req & ~((1<<ptr)-1); pick lowest set bit of masked, else lowest of req.
//   Candidate set excludes current owner when preempting.
//  States: IDLE, BUSY.
//  IDLE: if req!=0 -> grant=onehot(pick) at next edge, BUSY, hold_cnt=1, ptr=(pick+1)%N.
//   Latency req->grant = 1 cycle. req==0 -> stay IDLE, outputs 0.
//  BUSY, owner o:
//   req[o]=1 and (MAX_HOLD==0 or hold_cnt<MAX_HOLD or no other req) -> hold grant;
//    hold_cnt++ saturating at MAX_HOLD.
//   req[o]=0 (release): pick among req (o's bit is 0) with current ptr; if any -> new owner at next
//    edge, no idle bubble; hold_cnt=1; ptr=(new+1)%N. If none -> IDLE, grant=0 next edge.
//   Preempt: MAX_HOLD>0, hold_cnt==MAX_HOLD, req[o]=1 and (req & ~onehot(o))!=0 -> grant moves to
//    pick over req & ~onehot(o) at next edge; hold_cnt=1; ptr=(new+1)%N.
//  Wrap: owner N-1 -> ptr=0. Non-owner req toggling while BUSY: ignored until arbitration point.
//  Invariants: grant always one-hot or zero; grant_id==encode(grant); grant_valid==|grant.
//  Only one arbitration decision per cycle; all outputs registered, no combinational req->grant path.
// STRUCTURE
//  Package arb_pkg: arb_state_e {IDLE, BUSY}; onehot-to-index function; idx width localparam rule.
//  Sub-module rr_priority_pick: combinational, params N; inputs req, ptr, exclude mask;
//   outputs found, pick_id, pick_onehot (two LSB-first priority encoders, masked + unmasked).
//  Top: state reg, ptr reg, hold_cnt ($clog2(MAX_HOLD+1) bits, min 1), grant/id regs.
// TESTING  (N=4, MAX_HOLD=4)
//  1. Reset, req=0000 for 5 cycles -> grant=0000, grant_valid=0, grant_id=0 throughout.
//  2. req=0110 at cycle 0 -> grant=0010 at cycle 1, id=1; drop req[1] -> next cycle grant=0100, no gap.
//  3. req=1111 held, owners release after 1 cycle each -> grant sequence 0001,0010,0100,1000,0001.
//  4. req[0] held 10 cycles, req[2] asserted at cycle 2 -> grant[0] for 4 cycles, then 0100 next edge.
//  5. req[3] alone held 20 cycles -> grant=1000 continuous, no preemption, hold_cnt saturates at 4.
//  6. Owner 2 busy, rst=1 one cycle -> grant=0000 after edge; then req=1001 -> grant=0001 (ptr reset).

Source files
------------

// File: rtl/rr_hold_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rr_hold_arbiter_pkg
//  Description : Shared types and helpers for the round-robin hold arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package rr_hold_arbiter_pkg;

    // Widest requester vector the index helper can encode.
    localparam int unsigned c_max_n = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // OR-reduction encoder: exact for one-hot input, 0 for all-zero input.
    function automatic int unsigned onehot_to_idx(input logic [c_max_n-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < c_max_n; i++) begin
            if (oh[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

endpackage : rr_hold_arbiter_pkg
`default_nettype wire

// File: rtl/rr_hold_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : rr_hold_arbiter_if
//  Description : Request/grant bundle between requesters and the arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rr_hold_arbiter_if
    import rr_hold_arbiter_pkg::*;
#(
    parameter int N = 4
);
    localparam int IW = idx_width(N);

    logic [N-1:0]  req;
    logic [N-1:0]  grant;
    logic          grant_valid;
    logic [IW-1:0] grant_id;

    modport master (
        output req,
        input  grant,
        input  grant_valid,
        input  grant_id
    );

    modport slave (
        input  req,
        output grant,
        output grant_valid,
        output grant_id
    );

endinterface : rr_hold_arbiter_if
`default_nettype wire

// File: rtl/rr_hold_arbiter_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_hold_arbiter_pick
//  Description : Combinational round-robin pick: lowest request at or above
//                ptr, else lowest request overall, after removing excluded bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_hold_arbiter_pick
    import rr_hold_arbiter_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic [N-1:0]  exclude,
    output logic          found,
    output logic [IW-1:0] pick_id,
    output logic [N-1:0]  pick_onehot
);

    logic [N-1:0]       w_cand;
    logic [N-1:0]       w_thresh;
    logic [N-1:0]       w_masked;
    logic [N-1:0]       w_oh_masked;
    logic [N-1:0]       w_oh_any;
    logic [c_max_n-1:0] w_oh_ext;

    always_comb begin
        w_cand      = req & ~exclude;
        w_thresh    = '0;
        w_oh_masked = '0;
        w_oh_any    = '0;
        for (int i = 0; i < N; i++) begin
            w_thresh[i] = (IW'(i) >= ptr);
        end
        w_masked = w_cand & w_thresh;
        // Scan downwards so the last hit written is the lowest set bit.
        for (int i = N - 1; i >= 0; i--) begin
            if (w_masked[i]) begin
                w_oh_masked    = '0;
                w_oh_masked[i] = 1'b1;
            end
            if (w_cand[i]) begin
                w_oh_any    = '0;
                w_oh_any[i] = 1'b1;
            end
        end
        pick_onehot = (|w_masked) ? w_oh_masked : w_oh_any;
        found       = |w_cand;
        w_oh_ext    = c_max_n'(pick_onehot);
        pick_id     = IW'(onehot_to_idx(w_oh_ext));
    end

endmodule : rr_hold_arbiter_pick
`default_nettype wire

// File: rtl/rr_hold_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_hold_arbiter
//  Description : Round-robin arbiter with grant hold and bounded ownership.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_hold_arbiter
    import rr_hold_arbiter_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    localparam int IW = idx_width(N),
    localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1)
) (
    input  logic             clk,
    input  logic             rst,
    rr_hold_arbiter_if.slave bus
);

    localparam logic [HW-1:0] c_max_hold = HW'(MAX_HOLD);
    localparam logic [HW-1:0] c_cnt_one  = HW'(1);
    localparam logic [IW-1:0] c_last_id  = IW'(N - 1);

    arb_state_e    r_state, w_state_nxt;
    logic [IW-1:0] r_ptr, w_ptr_nxt;
    logic [HW-1:0] r_hold_cnt, w_hold_cnt_nxt;
    logic [N-1:0]  r_grant, w_grant_nxt;
    logic [IW-1:0] r_grant_id, w_grant_id_nxt;
    logic          r_grant_valid, w_grant_valid_nxt;

    logic [N-1:0]  w_exclude;
    logic          w_found;
    logic [IW-1:0] w_pick_id;
    logic [N-1:0]  w_pick_onehot;
    logic          w_owner_req;
    logic          w_others_req;
    logic          w_preempt;
    logic          w_take;
    logic [IW-1:0] w_ptr_after;
    logic [HW-1:0] w_hold_inc;

    // While busy the owner is never a candidate; on release its bit is already 0.
    assign w_exclude = (r_state == BUSY) ? r_grant : '0;

    rr_hold_arbiter_pick #(
        .N (N)
    ) u_pick (
        .req         (bus.req),
        .ptr         (r_ptr),
        .exclude     (w_exclude),
        .found       (w_found),
        .pick_id     (w_pick_id),
        .pick_onehot (w_pick_onehot)
    );

    assign w_owner_req  = |(bus.req & r_grant);
    assign w_others_req = |(bus.req & ~r_grant);
    assign w_preempt    = (MAX_HOLD != 0) && (r_hold_cnt == c_max_hold) && w_others_req;
    assign w_ptr_after  = (w_pick_id == c_last_id) ? '0 : w_pick_id + IW'(1);
    assign w_hold_inc   = ((MAX_HOLD == 0) || (r_hold_cnt == c_max_hold))
                          ? r_hold_cnt : r_hold_cnt + c_cnt_one;
    assign w_take       = w_found && ((r_state == IDLE) || !w_owner_req || w_preempt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_ptr         <= '0;
            r_hold_cnt    <= '0;
            r_grant       <= '0;
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ptr         <= w_ptr_nxt;
            r_hold_cnt    <= w_hold_cnt_nxt;
            r_grant       <= w_grant_nxt;
            r_grant_id    <= w_grant_id_nxt;
            r_grant_valid <= w_grant_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_ptr_nxt         = r_ptr;
        w_hold_cnt_nxt    = r_hold_cnt;
        w_grant_nxt       = r_grant;
        w_grant_id_nxt    = r_grant_id;
        w_grant_valid_nxt = r_grant_valid;

        if (w_take) begin
            w_state_nxt       = BUSY;
            w_grant_nxt       = w_pick_onehot;
            w_grant_id_nxt    = w_pick_id;
            w_grant_valid_nxt = 1'b1;
            w_hold_cnt_nxt    = c_cnt_one;
            w_ptr_nxt         = w_ptr_after;
        end else if ((r_state == BUSY) && w_owner_req) begin
            w_hold_cnt_nxt = w_hold_inc;
        end else if (r_state == BUSY) begin
            // Owner released with nobody else waiting.
            w_state_nxt       = IDLE;
            w_grant_nxt       = '0;
            w_grant_id_nxt    = '0;
            w_grant_valid_nxt = 1'b0;
            w_hold_cnt_nxt    = '0;
        end
    end

    assign bus.grant       = r_grant;
    assign bus.grant_id    = r_grant_id;
    assign bus.grant_valid = r_grant_valid;

endmodule : rr_hold_arbiter
`default_nettype wire

// File: tb/tb_rr_hold_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_hold_arbiter
//  Description : Directed self-checking bench for rr_hold_arbiter (N=4, MAX_HOLD=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_hold_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    rr_hold_arbiter_if #(.N(N)) bus ();

    rr_hold_arbiter #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic logic [1:0] exp_id(input logic [3:0] g);
        logic [1:0] id;
        id = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) id = 2'(i);
        end
        return id;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bus.req = '0;
        step();
        rst     = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] eg;
        eg = 4'b0000;
        rst     = 1'b1;
        bus.req = '0;
        step();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            n_checks++;
            if (bus.grant !== eg || bus.grant_valid !== 1'b0 || bus.grant_id !== 2'd0)
                $display("FAIL reset[%0d]: grant=%b valid=%b id=%0d, expected grant=%b valid=0 id=0",
                         c, bus.grant, bus.grant_valid, bus.grant_id, eg);
            else n_pass++;
            step();
        end
    endtask

    task automatic test_handover();
        logic [3:0] reqs [3] = '{4'b0110, 4'b0100, 4'b0000};
        logic [3:0] exps [3] = '{4'b0010, 4'b0100, 4'b0000};
        do_reset();
        for (int c = 0; c < 3; c++) begin
            bus.req = reqs[c];
            step();
            n_checks++;
            if (bus.grant !== exps[c] || bus.grant_valid !== (exps[c] != 0) || bus.grant_id !== exp_id(exps[c]))
                $display("FAIL handover[%0d]: grant=%b valid=%b id=%0d, expected grant=%b id=%0d",
                         c, bus.grant, bus.grant_valid, bus.grant_id, exps[c], exp_id(exps[c]));
            else n_pass++;
        end
    endtask

    task automatic test_rotation();
        logic [3:0] reqs [5] = '{4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [3:0] exps [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            bus.req = reqs[c];
            step();
            n_checks++;
            if (bus.grant !== exps[c] || bus.grant_valid !== 1'b1 || bus.grant_id !== exp_id(exps[c]))
                $display("FAIL rotation[%0d]: grant=%b valid=%b id=%0d, expected grant=%b id=%0d",
                         c, bus.grant, bus.grant_valid, bus.grant_id, exps[c], exp_id(exps[c]));
            else n_pass++;
        end
        bus.req = '0;
        step();
    endtask

    task automatic test_preempt();
        // Owner 0 keeps 4 cycles, then 2 takes over, then wraps back to 0.
        logic [3:0] reqs [10] = '{4'b0001, 4'b0101, 4'b0101, 4'b0101, 4'b0101,
                                  4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0000};
        logic [3:0] exps [10] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0100,
                                  4'b0100, 4'b0100, 4'b0100, 4'b0001, 4'b0000};
        do_reset();
        for (int c = 0; c < 10; c++) begin
            bus.req = reqs[c];
            step();
            n_checks++;
            if (bus.grant !== exps[c] || bus.grant_valid !== (exps[c] != 0) || bus.grant_id !== exp_id(exps[c]))
                $display("FAIL preempt[%0d]: grant=%b valid=%b id=%0d, expected grant=%b id=%0d",
                         c, bus.grant, bus.grant_valid, bus.grant_id, exps[c], exp_id(exps[c]));
            else n_pass++;
        end
    endtask

    task automatic test_solo_hold();
        logic [3:0] eg;
        do_reset();
        bus.req = 4'b1000;
        eg      = 4'b1000;
        for (int c = 0; c < 20; c++) begin
            step();
            n_checks++;
            if (bus.grant !== eg || bus.grant_valid !== 1'b1 || bus.grant_id !== 2'd3)
                $display("FAIL solo_hold[%0d]: grant=%b valid=%b id=%0d, expected grant=%b id=3",
                         c, bus.grant, bus.grant_valid, bus.grant_id, eg);
            else n_pass++;
        end
        // Counter is saturated, so a new waiter preempts on the very next edge.
        bus.req = 4'b1001;
        step();
        n_checks++;
        if (bus.grant !== 4'b0001 || bus.grant_valid !== 1'b1 || bus.grant_id !== 2'd0)
            $display("FAIL solo_preempt: grant=%b valid=%b id=%0d, expected grant=0001 id=0",
                     bus.grant, bus.grant_valid, bus.grant_id);
        else n_pass++;
        bus.req = '0;
        step();
    endtask

    task automatic test_mid_reset();
        do_reset();
        bus.req = 4'b0100;
        step();
        step();
        n_checks++;
        if (bus.grant !== 4'b0100 || bus.grant_id !== 2'd2)
            $display("FAIL midrst_owner: grant=%b id=%0d, expected grant=0100 id=2",
                     bus.grant, bus.grant_id);
        else n_pass++;
        rst = 1'b1;
        step();
        n_checks++;
        if (bus.grant !== 4'b0000 || bus.grant_valid !== 1'b0 || bus.grant_id !== 2'd0)
            $display("FAIL midrst_drop: grant=%b valid=%b id=%0d, expected grant=0000 valid=0 id=0",
                     bus.grant, bus.grant_valid, bus.grant_id);
        else n_pass++;
        rst     = 1'b0;
        bus.req = 4'b1001;
        step();
        n_checks++;
        if (bus.grant !== 4'b0001 || bus.grant_valid !== 1'b1 || bus.grant_id !== 2'd0)
            $display("FAIL midrst_ptr: grant=%b valid=%b id=%0d, expected grant=0001 id=0",
                     bus.grant, bus.grant_valid, bus.grant_id);
        else n_pass++;
        bus.req = '0;
        step();
    endtask

    initial begin
        rst     = 1'b1;
        bus.req = '0;
        test_reset();
        test_handover();
        test_rotation();
        test_preempt();
        test_solo_hold();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_rr_hold_arbiter
`default_nettype wire
